// File: rtl/clacc_cap_mem.sv
// Multi-channel capture memory: one bank plus a written-bitmap per channel,
// cleared by a post-reset sweep, with per-channel distinct-write counters and error flags.
//
// state  | meaning
// S_INIT | sweep clears data and bitmap of every bank, one address per cycle
// S_RUN  | captures writes and serves reads; left only by reset
module clacc_cap_mem #(
  parameter int CH     = 3,
  parameter int AW     = 14,
  parameter int DW     = 8,
  parameter int EXPECT = 16384,
  localparam int CW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CH-1:0]        wr_valid,
  input  logic [CH*AW-1:0]     wr_addr,
  input  logic [CH*DW-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [CW-1:0]        rd_ch,
  input  logic [AW-1:0]        rd_addr,
  output logic                 rd_valid,
  output logic [DW-1:0]        rd_data,
  output logic                 rd_written,
  output logic                 init_busy,
  output logic [CH-1:0]        done,
  output logic [CH*(AW+1)-1:0] wr_cnt,
  output logic [CH-1:0]        err_rewrite,
  output logic [CH-1:0]        err_drop
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     sweep_q;
  logic [DW-1:0]     mem   [CH][DEPTH];
  logic [DEPTH-1:0]  wbits [CH];
  logic [AW-1:0]     wa    [CH];
  logic [DW-1:0]     wd    [CH];
  logic [CH-1:0]     old_bit;
  logic [AW:0]       cnt_q [CH];
  logic              run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    init_busy = 1'b0;
    run       = 1'b0;
    case (state_q)
      S_INIT: begin
        init_busy = 1'b1;
        if (sweep_q == {AW{1'b1}}) state_d = S_RUN;
      end
      S_RUN: begin
        run = 1'b1;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sweep_q <= '0;
    end else if (state_q == S_INIT) begin
      sweep_q <= sweep_q + 1'b1;
    end
  end

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      wa[c]      = wr_addr[c*AW +: AW];
      wd[c]      = wr_data[c*DW +: DW];
      old_bit[c] = wbits[c][wa[c]];
    end
  end

  // Storage has no reset; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (!run) begin
        mem[c][sweep_q]   <= '0;
        wbits[c][sweep_q] <= 1'b0;
      end else if (wr_valid[c]) begin
        mem[c][wa[c]]   <= wd[c];
        wbits[c][wa[c]] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_rewrite <= '0;
      err_drop    <= '0;
      for (int c = 0; c < CH; c++) cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (wr_valid[c]) begin
          if (!run)            err_drop[c]    <= 1'b1;
          else if (old_bit[c]) err_rewrite[c] <= 1'b1;
          else                 cnt_q[c]       <= cnt_q[c] + 1'b1;
        end
      end
    end
  end

  // Read-first: the array reads here see pre-edge contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_written <= 1'b0;
    end else begin
      rd_valid <= run && rd_en;
      if (run && rd_en) begin
        if ({1'b0, rd_ch} < (CW+1)'(CH)) begin
          rd_data    <= mem[rd_ch][rd_addr];
          rd_written <= wbits[rd_ch][rd_addr];
        end else begin
          rd_data    <= '0;
          rd_written <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_out
    assign wr_cnt[g*(AW+1) +: AW+1] = cnt_q[g];
    assign done[g] = (cnt_q[g] >= (AW+1)'(EXPECT));
  end

endmodule

// File: tb/tb_clacc_cap_mem.sv
// Directed self-checking bench for clacc_cap_mem (CH=3, AW=4, DW=8, EXPECT=16).
module tb_clacc_cap_mem;

  localparam int CH = 3, AW = 4, DW = 8, EXPECT = 16, CW = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [CH-1:0]        wr_valid = '0;
  logic [CH*AW-1:0]     wr_addr = '0;
  logic [CH*DW-1:0]     wr_data = '0;
  logic                 rd_en = 1'b0;
  logic [CW-1:0]        rd_ch = '0;
  logic [AW-1:0]        rd_addr = '0;
  logic                 rd_valid;
  logic [DW-1:0]        rd_data;
  logic                 rd_written;
  logic                 init_busy;
  logic [CH-1:0]        done;
  logic [CH*(AW+1)-1:0] wr_cnt;
  logic [CH-1:0]        err_rewrite;
  logic [CH-1:0]        err_drop;

  int checks = 0;
  int errors = 0;

  clacc_cap_mem #(.CH(CH), .AW(AW), .DW(DW), .EXPECT(EXPECT)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_written(rd_written),
    .init_busy(init_busy), .done(done), .wr_cnt(wr_cnt),
    .err_rewrite(err_rewrite), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  function automatic logic [AW:0] cnt_of(input int c);
    return wr_cnt[c*(AW+1) +: AW+1];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after release until init_busy drops (bounded).
  task automatic wait_init(output int n);
    n = 0;
    while (init_busy && n < 40) begin
      tick();
      n++;
    end
    if (init_busy) begin
      errors++;
      $display("FAIL wait_init: init_busy still 1 after %0d cycles", n);
    end
  endtask

  task automatic apply_reset(output int n);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    wait_init(n);
  endtask

  task automatic do_write(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr[ch*AW +: AW] = a;
    wr_data[ch*DW +: DW] = d;
    wr_valid[ch] = 1'b1;
    tick();
    wr_valid = '0;
  endtask

  task automatic do_read(input int ch, input logic [AW-1:0] a,
                         output logic [DW-1:0] d, output logic w, output logic v);
    rd_ch = CW'(ch);
    rd_addr = a;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    d = rd_data;
    w = rd_written;
    v = rd_valid;
  endtask

  task automatic test_reset();
    int n;
    logic [DW-1:0] d; logic w, v;
    reset = 1'b1;
    tick();
    checks++;
    if (init_busy !== 1'b1 || rd_valid !== 1'b0 || rd_data !== '0 || done !== '0 ||
        wr_cnt !== '0 || err_rewrite !== '0 || err_drop !== '0) begin
      errors++;
      $display("FAIL reset_values: busy=%b rv=%b rd=%h done=%b cnt=%h rew=%b drop=%b, need 1 0 00 0 0 0 0",
               init_busy, rd_valid, rd_data, done, wr_cnt, err_rewrite, err_drop);
    end
    reset = 1'b0;
    wait_init(n);
    checks++;
    if (n !== 16) begin errors++; $display("FAIL init_len: got %0d cycles, need 16", n); end
    for (int c = 0; c < CH; c++)
      for (int a = 0; a < 16; a++) begin
        do_read(c, AW'(a), d, w, v);
        checks++;
        if (v !== 1'b1 || d !== 8'h00 || w !== 1'b0) begin
          errors++;
          $display("FAIL init_clear ch%0d a%0d: v=%b d=%h w=%b, need 1 00 0", c, a, v, d, w);
        end
      end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || done !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_read: rd_valid=%b done=%b, need 0 000", rd_valid, done);
    end
  endtask

  task automatic test_fill();
    int n;
    logic [DW-1:0] d; logic w, v;
    apply_reset(n);
    for (int k = 0; k < 16; k++) begin
      do_write(0, AW'(k), 8'hA0 + 8'(k));
      checks++;
      if (cnt_of(0) !== 5'(k + 1)) begin
        errors++; $display("FAIL fill_cnt k=%0d: got %0d, need %0d", k, cnt_of(0), k + 1);
      end
      checks++;
      if (done !== ((k == 15) ? 3'b001 : 3'b000)) begin
        errors++; $display("FAIL fill_done k=%0d: got %b, need %b", k, done, (k == 15) ? 3'b001 : 3'b000);
      end
    end
    for (int k = 0; k < 16; k++) begin
      do_read(0, AW'(k), d, w, v);
      checks++;
      if (v !== 1'b1 || d !== 8'hA0 + 8'(k) || w !== 1'b1) begin
        errors++; $display("FAIL fill_read a%0d: v=%b d=%h w=%b, need 1 %h 1", k, v, d, w, 8'hA0 + 8'(k));
      end
    end
  endtask

  task automatic test_simultaneous();
    int n;
    logic [DW-1:0] d; logic w, v;
    logic [DW-1:0] exp_d [CH];
    exp_d[0] = 8'd11; exp_d[1] = 8'd22; exp_d[2] = 8'd33;
    apply_reset(n);
    wr_addr = {4'd5, 4'd5, 4'd5};
    wr_data = {8'd33, 8'd22, 8'd11};
    wr_valid = 3'b111;
    tick();
    wr_valid = '0;
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (cnt_of(c) !== 5'd1) begin errors++; $display("FAIL simul_cnt ch%0d: got %0d, need 1", c, cnt_of(c)); end
      do_read(c, 4'd5, d, w, v);
      checks++;
      if (d !== exp_d[c] || w !== 1'b1) begin
        errors++; $display("FAIL simul_read ch%0d: d=%0d w=%b, need %0d 1", c, d, w, exp_d[c]);
      end
    end
    checks++;
    if (err_rewrite !== 3'b000) begin errors++; $display("FAIL simul_rew: got %b, need 000", err_rewrite); end
    do_read(3, 4'd5, d, w, v);
    checks++;
    if (v !== 1'b1 || d !== 8'h00 || w !== 1'b0) begin
      errors++; $display("FAIL bad_ch_read: v=%b d=%h w=%b, need 1 00 0", v, d, w);
    end
  endtask

  task automatic test_rewrite();
    int n;
    logic [DW-1:0] d; logic w, v;
    apply_reset(n);
    do_write(1, 4'd3, 8'd7);
    checks++;
    if (err_rewrite !== 3'b000) begin errors++; $display("FAIL rew_first: got %b, need 000", err_rewrite); end
    do_write(1, 4'd3, 8'd9);
    checks++;
    if (err_rewrite !== 3'b010 || cnt_of(1) !== 5'd1) begin
      errors++; $display("FAIL rew_second: rew=%b cnt1=%0d, need 010 1", err_rewrite, cnt_of(1));
    end
    do_read(1, 4'd3, d, w, v);
    checks++;
    if (d !== 8'd9 || w !== 1'b1) begin errors++; $display("FAIL rew_read: d=%0d w=%b, need 9 1", d, w); end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'd9) begin
      errors++; $display("FAIL read_hold: rv=%b d=%0d, need 0 9", rd_valid, rd_data);
    end
  endtask

  task automatic test_drop();
    int n;
    logic [DW-1:0] d; logic w, v;
    reset = 1'b1;
    wr_addr[2*AW +: AW] = 4'd7;
    wr_data[2*DW +: DW] = 8'hFF;
    wr_valid[2] = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    wait_init(n);
    wr_valid = '0;
    checks++;
    if (err_drop !== 3'b100 || cnt_of(2) !== 5'd0 || done !== 3'b000) begin
      errors++; $display("FAIL drop_flags: drop=%b cnt2=%0d done=%b, need 100 0 000", err_drop, cnt_of(2), done);
    end
    for (int a = 0; a < 16; a++) begin
      do_read(2, AW'(a), d, w, v);
      checks++;
      if (d !== 8'h00 || w !== 1'b0) begin
        errors++; $display("FAIL drop_bank a%0d: d=%h w=%b, need 00 0", a, d, w);
      end
    end
  endtask

  task automatic test_read_first();
    int n;
    logic [DW-1:0] d; logic w, v;
    apply_reset(n);
    do_write(0, 4'd4, 8'h10);
    wr_addr[0 +: AW] = 4'd4;
    wr_data[0 +: DW] = 8'h20;
    wr_valid[0] = 1'b1;
    rd_ch = 2'd0;
    rd_addr = 4'd4;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    wr_valid = '0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h10 || rd_written !== 1'b1) begin
      errors++; $display("FAIL rf_old: v=%b d=%h w=%b, need 1 10 1", rd_valid, rd_data, rd_written);
    end
    checks++;
    if (err_rewrite !== 3'b001 || cnt_of(0) !== 5'd1) begin
      errors++; $display("FAIL rf_flags: rew=%b cnt0=%0d, need 001 1", err_rewrite, cnt_of(0));
    end
    do_read(0, 4'd4, d, w, v);
    checks++;
    if (d !== 8'h20 || w !== 1'b1) begin errors++; $display("FAIL rf_new: d=%h w=%b, need 20 1", d, w); end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    logic [DW-1:0] d; logic w, v;
    // Leave errors behind from the previous run: err_rewrite[0] is set.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_ch = 2'd0;
    rd_addr = 4'd4;
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (init_busy !== 1'b1 || rd_valid !== 1'b0) begin
        errors++; $display("FAIL sweep_busy i=%0d: busy=%b rv=%b, need 1 0", i, init_busy, rd_valid);
      end
    end
    rd_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_init(n);
    checks++;
    if (n !== 16) begin errors++; $display("FAIL restart_len: got %0d cycles, need 16", n); end
    checks++;
    if (err_rewrite !== '0 || err_drop !== '0 || wr_cnt !== '0 || done !== '0) begin
      errors++; $display("FAIL restart_clear: rew=%b drop=%b cnt=%h done=%b, need 0 0 0 0",
                         err_rewrite, err_drop, wr_cnt, done);
    end
    do_read(0, 4'd4, d, w, v);
    checks++;
    if (d !== 8'h00 || w !== 1'b0) begin errors++; $display("FAIL restart_mem: d=%h w=%b, need 00 0", d, w); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_simultaneous();
    test_rewrite();
    test_drop();
    test_read_first();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
